// File: rtl/xadc_drp_channel_sequencer.sv
// xadc_drp_channel_sequencer
// Each XADC end-of-sequence pulse starts a walk over the configured channel
// addresses. The walk issues one DRP read per channel and hands each result
// to that channel's AXI-Stream holding register.
// A full holding register drops the new sample and bumps a saturating
// overflow counter. Reads with no drdy are abandoned after a bounded wait.
// Optional build macro XADC_SEQ_AVG_EN: average 2**AVG_LOG2 samples per
// channel before emitting, instead of emitting every raw sample.
module xadc_drp_channel_sequencer #(
    parameter int                      NUM_CHANNELS   = 2,
    parameter logic [NUM_CHANNELS*7-1:0] CHANNEL_ADDR = {7'h1C, 7'h14},
    parameter int                      TIMEOUT_CYCLES = 64,
    parameter int                      AVG_LOG2       = 2
) (
    input  logic                         xadc_dclk,
    input  logic                         xadc_reset_n,
    input  logic                         xadc_eos,
    output logic                         xadc_den,
    output logic [6:0]                   xadc_daddr,
    input  logic                         xadc_drdy,
    input  logic [15:0]                  xadc_do,
    output logic [NUM_CHANNELS*16-1:0]   m_axis_tdata,
    output logic [NUM_CHANNELS-1:0]      m_axis_tvalid,
    input  logic [NUM_CHANNELS-1:0]      m_axis_tready,
    output logic [15:0]                  overflow_count,
    output logic                         timeout_err,
    output logic                         seq_overrun,
    output logic                         busy
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE,
        ST_NEXT
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [15:0]        sample_q;
    logic [6:0]         cur_addr;
    logic               emit_en;
    logic [15:0]        emit_word;

    // Select the DRP address of the channel currently being read
    always_comb begin
        cur_addr = 7'd0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_addr = CHANNEL_ADDR[7*i +: 7];
            end
        end
    end

`ifdef XADC_SEQ_AVG_EN
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;

    logic [ACC_W-1:0] acc_q [NUM_CHANNELS];
    logic [CNT_W-1:0] cnt_q [NUM_CHANNELS];
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             avg_full;
    logic             unused_low_bits;

    assign unused_low_bits = ^sample_q[3:0];

    // Running sum for the active channel; the top 12 bits of the sum are the mean
    always_comb begin
        acc_next  = acc_q[idx] + ACC_W'(sample_q[15:4]);
        cnt_next  = cnt_q[idx] + CNT_W'(1);
        avg_full  = (cnt_next == CNT_W'(1 << AVG_LOG2));
        emit_en   = avg_full;
        emit_word = {acc_next[ACC_W-1 -: 12], 4'b0000};
    end

    // Accumulate on every stored sample; a completed block restarts from zero whether or not it was emitted
    always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
        if (!xadc_reset_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (state == ST_STORE) begin
            if (avg_full) begin
                acc_q[idx] <= '0;
                cnt_q[idx] <= '0;
            end else begin
                acc_q[idx] <= acc_next;
                cnt_q[idx] <= cnt_next;
            end
        end
    end
`else
    // Raw mode forwards every captured DRP word unchanged
    always_comb begin
        emit_en   = 1'b1;
        emit_word = sample_q;
    end
`endif

    // Sequencer FSM plus the per-channel stream holding registers and status flags
    always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
        if (!xadc_reset_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            tmo_cnt        <= '0;
            sample_q       <= '0;
            xadc_den       <= 1'b0;
            xadc_daddr     <= 7'd0;
            m_axis_tdata   <= '0;
            m_axis_tvalid  <= '0;
            overflow_count <= 16'd0;
            timeout_err    <= 1'b0;
            seq_overrun    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (m_axis_tvalid[i] && m_axis_tready[i]) begin
                    m_axis_tvalid[i] <= 1'b0;
                end
            end

            if (xadc_eos && (state != ST_IDLE)) begin
                seq_overrun <= 1'b1;
            end

            xadc_den <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (xadc_eos) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    xadc_den   <= 1'b1;
                    xadc_daddr <= cur_addr;
                    tmo_cnt    <= '0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (xadc_drdy) begin
                        sample_q <= xadc_do;
                        state    <= ST_STORE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ST_NEXT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_STORE: begin
                    if (emit_en) begin
                        if (!m_axis_tvalid[idx] || m_axis_tready[idx]) begin
                            m_axis_tdata[16*idx +: 16] <= emit_word;
                            m_axis_tvalid[idx]         <= 1'b1;
                        end else if (overflow_count != 16'hFFFF) begin
                            overflow_count <= overflow_count + 16'd1;
                        end
                    end
                    state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (idx == IDX_LAST) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= ST_ISSUE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_drp_channel_sequencer.sv
// tb_xadc_drp_channel_sequencer
// Directed and randomized sequences against a transaction-level model that
// tracks, per channel, the samples that should appear on the stream and
// the sample left sitting in the holding register.
// The model also tracks the drop count and the sticky flags.
// Honours XADC_SEQ_AVG_EN when the design is built with it.
module tb_xadc_drp_channel_sequencer;

    localparam int NUM_CH   = 2;
    localparam int TMO      = 64;
    localparam int AVG_LOG2 = 2;

    logic                 xadc_dclk = 1'b0;
    logic                 xadc_reset_n;
    logic                 xadc_eos;
    logic                 xadc_den;
    logic [6:0]           xadc_daddr;
    logic                 xadc_drdy;
    logic [15:0]          xadc_do;
    logic [NUM_CH*16-1:0] m_axis_tdata;
    logic [NUM_CH-1:0]    m_axis_tvalid;
    logic [NUM_CH-1:0]    m_axis_tready;
    logic [15:0]          overflow_count;
    logic                 timeout_err;
    logic                 seq_overrun;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    // DRP responder configuration, indexed by DRP address
    int          rsp_lat   [128];
    logic [15:0] rsp_data  [128];
    bit          rsp_never [128];
    logic [6:0]  ch_addr   [NUM_CH] = '{7'h14, 7'h1C};

    // Observed traffic
    int          got_cnt  [NUM_CH];
    logic [15:0] got_data [NUM_CH][256];
    int          den_cnt  [128];
    logic [6:0]  den_log  [512];
    int          den_n;

    // Reference model state
    bit          m_tready [NUM_CH];
    bit          hold_v   [NUM_CH];
    logic [15:0] hold_d   [NUM_CH];
    int          exp_cnt  [NUM_CH];
    logic [15:0] exp_data [NUM_CH][256];
    int          chk_idx  [NUM_CH];
    int          acc      [NUM_CH];
    int          acnt     [NUM_CH];
    int          exp_ovf;
    bit          exp_to;
    bit          exp_ovr;

    xadc_drp_channel_sequencer #(
        .NUM_CHANNELS   (NUM_CH),
        .CHANNEL_ADDR   ({7'h1C, 7'h14}),
        .TIMEOUT_CYCLES (TMO),
        .AVG_LOG2       (AVG_LOG2)
    ) dut (
        .xadc_dclk      (xadc_dclk),
        .xadc_reset_n   (xadc_reset_n),
        .xadc_eos       (xadc_eos),
        .xadc_den       (xadc_den),
        .xadc_daddr     (xadc_daddr),
        .xadc_drdy      (xadc_drdy),
        .xadc_do        (xadc_do),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .overflow_count (overflow_count),
        .timeout_err    (timeout_err),
        .seq_overrun    (seq_overrun),
        .busy           (busy)
    );

    always #5 xadc_dclk = ~xadc_dclk;

    // DRP slave: answers each den after the configured latency unless told to stay silent
    initial begin : drp_responder
        logic [6:0] a;
        xadc_drdy = 1'b0;
        xadc_do   = 16'hDEAD;
        forever begin
            @(negedge xadc_dclk);
            if (xadc_den === 1'b1 && !rsp_never[xadc_daddr]) begin
                a = xadc_daddr;
                repeat (rsp_lat[a] - 1) @(negedge xadc_dclk);
                xadc_drdy = 1'b1;
                xadc_do   = rsp_data[a];
                @(negedge xadc_dclk);
                xadc_drdy = 1'b0;
                xadc_do   = 16'hDEAD;
            end
        end
    end

    // Monitor: record completed stream handshakes and every den pulse
    initial begin : monitor
        den_n = 0;
        for (int i = 0; i < 128; i++) den_cnt[i] = 0;
        for (int c = 0; c < NUM_CH; c++) got_cnt[c] = 0;
        forever begin
            @(negedge xadc_dclk);
            #3;
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_axis_tvalid[c] === 1'b1 && m_axis_tready[c] === 1'b1 && got_cnt[c] < 256) begin
                    got_data[c][got_cnt[c]] = m_axis_tdata[16*c +: 16];
                    got_cnt[c]++;
                end
            end
            if (xadc_den === 1'b1) begin
                den_cnt[xadc_daddr]++;
                if (den_n < 512) den_log[den_n] = xadc_daddr;
                den_n++;
            end
        end
    end

    // Hard stop in case the sequencer or bench wedges
    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_neg();
        @(negedge xadc_dclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input int ch, input logic [15:0] v);
        if (exp_cnt[ch] < 256) exp_data[ch][exp_cnt[ch]] = v;
        exp_cnt[ch]++;
    endtask

    // One DRP result reaching the channel's stream: emit, hold, or drop
    task automatic model_sample(input int ch, input logic [15:0] v);
        logic [15:0] w;
        w = v;
`ifdef XADC_SEQ_AVG_EN
        acc[ch]  += int'(v[15:4]);
        acnt[ch] += 1;
        if (acnt[ch] < (1 << AVG_LOG2)) return;
        w = {12'(acc[ch] >> AVG_LOG2), 4'h0};
        acc[ch]  = 0;
        acnt[ch] = 0;
`endif
        if (m_tready[ch]) begin
            model_push(ch, w);
        end else if (!hold_v[ch]) begin
            hold_v[ch] = 1'b1;
            hold_d[ch] = w;
        end else if (exp_ovf < 65535) begin
            exp_ovf++;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            hold_v[c] = 1'b0;
            acc[c]    = 0;
            acnt[c]   = 0;
        end
        exp_ovf = 0;
        exp_to  = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic set_tready(input int ch, input bit val);
        if (val && hold_v[ch]) begin
            model_push(ch, hold_d[ch]);
            hold_v[ch] = 1'b0;
        end
        m_tready[ch]      = val;
        m_axis_tready[ch] = val;
    endtask

    task automatic pulse_eos();
        wait_neg();
        xadc_eos = 1'b1;
        wait_neg();
        xadc_eos = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            wait_neg();
            n++;
        end
        check("seq_done_busy", 32'(busy), 32'd0);
        repeat (3) wait_neg();
    endtask

    task automatic configure(input logic [15:0] d0, input logic [15:0] d1,
                             input int l0, input int l1, input bit n0, input bit n1);
        rsp_data[ch_addr[0]]  = d0;
        rsp_data[ch_addr[1]]  = d1;
        rsp_lat[ch_addr[0]]   = l0;
        rsp_lat[ch_addr[1]]   = l1;
        rsp_never[ch_addr[0]] = n0;
        rsp_never[ch_addr[1]] = n1;
        if (n0) exp_to = 1'b1; else model_sample(0, d0);
        if (n1) exp_to = 1'b1; else model_sample(1, d1);
    endtask

    task automatic apply_stimulus(input logic [15:0] d0, input logic [15:0] d1,
                                  input int l0, input int l1, input bit n0, input bit n1);
        configure(d0, d1, l0, l1, n0, n1);
        pulse_eos();
        wait_idle();
    endtask

    task automatic check_output();
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("ch%0d_sample_count", c), 32'(got_cnt[c]), 32'(exp_cnt[c]));
            for (int k = chk_idx[c]; k < got_cnt[c] && k < exp_cnt[c] && k < 256; k++) begin
                check($sformatf("ch%0d_sample%0d", c, k), 32'(got_data[c][k]), 32'(exp_data[c][k]));
            end
            chk_idx[c] = got_cnt[c];
            check($sformatf("ch%0d_tvalid", c), 32'(m_axis_tvalid[c]), 32'(hold_v[c]));
            if (hold_v[c]) begin
                check($sformatf("ch%0d_held_tdata", c), 32'(m_axis_tdata[16*c +: 16]), 32'(hold_d[c]));
            end
        end
        check("overflow_count", 32'(overflow_count), 32'(exp_ovf));
        check("timeout_err", 32'(timeout_err), 32'(exp_to));
        check("seq_overrun", 32'(seq_overrun), 32'(exp_ovr));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_den"}, 32'(xadc_den), 32'd0);
        check({tag, "_daddr"}, 32'(xadc_daddr), 32'd0);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_tdata"}, 32'(m_axis_tdata), 32'd0);
        check({tag, "_overflow"}, 32'(overflow_count), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_seq_overrun"}, 32'(seq_overrun), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin : stimulus
        int d14, d1c, base_n;
        xadc_reset_n  = 1'b0;
        xadc_eos      = 1'b0;
        m_axis_tready = '1;
        for (int i = 0; i < 128; i++) begin
            rsp_lat[i]   = 3;
            rsp_data[i]  = 16'h0;
            rsp_never[i] = 1'b0;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            m_tready[c] = 1'b1;
            exp_cnt[c]  = 0;
            chk_idx[c]  = 0;
        end
        model_reset();

        // Reset state
        repeat (3) wait_neg();
        check_reset_values("reset");
        xadc_reset_n = 1'b1;
        repeat (2) wait_neg();

        // Basic sequence: addresses issued in channel order, both samples emitted
        $display("[TB] basic sequence");
        apply_stimulus(16'h8000, 16'h4000, 3, 3, 1'b0, 1'b0);
        check("den_count", 32'(den_n), 32'd2);
        check("den_first_addr", 32'(den_log[0]), 32'h14);
        check("den_second_addr", 32'(den_log[1]), 32'h1C);
        check_output();

        // Backpressure on channel 1 over three sequences
        $display("[TB] backpressure on channel 1");
        set_tready(1, 1'b0);
        for (int s = 0; s < 3; s++) begin
            apply_stimulus(16'($urandom), 16'($urandom), 3, 3, 1'b0, 1'b0);
            check_output();
        end
        set_tready(1, 1'b1);
        repeat (3) wait_neg();
        check_output();

        // Channel 0 never answers
        $display("[TB] DRP timeout on channel 0");
        apply_stimulus(16'($urandom), 16'($urandom), 3, 3, 1'b1, 1'b0);
        check_output();

        // Second EOS two cycles after the first
        $display("[TB] sequence overrun");
        d14 = den_cnt[7'h14];
        d1c = den_cnt[7'h1C];
        configure(16'($urandom), 16'($urandom), 2, 2, 1'b0, 1'b0);
        exp_ovr = 1'b1;
        pulse_eos();
        wait_neg();
        xadc_eos = 1'b1;
        wait_neg();
        xadc_eos = 1'b0;
        wait_idle();
        check("overrun_den_ch0", 32'(den_cnt[7'h14] - d14), 32'd1);
        check("overrun_den_ch1", 32'(den_cnt[7'h1C] - d1c), 32'd1);
        check_output();

        // Randomized sequences with random latency, readiness and occasional timeouts
        $display("[TB] randomized sequences");
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < NUM_CH; c++) set_tready(c, $urandom_range(0, 3) != 0);
            apply_stimulus(16'($urandom), 16'($urandom),
                           int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            check_output();
        end
        for (int c = 0; c < NUM_CH; c++) set_tready(c, 1'b1);
        repeat (3) wait_neg();
        check_output();

        // Reset while waiting for drdy; the late drdy must be ignored
        $display("[TB] reset during DRP wait");
        rsp_lat[7'h14]   = 12;
        rsp_never[7'h14] = 1'b0;
        rsp_data[7'h14]  = 16'h1234;
        base_n = den_n;
        pulse_eos();
        repeat (4) wait_neg();
        xadc_reset_n = 1'b0;
        model_reset();
        wait_neg();
        check_reset_values("in_reset");
        xadc_reset_n = 1'b1;
        repeat (20) wait_neg();
        check_reset_values("after_reset");
        check("after_reset_den_count", 32'(den_n), 32'(base_n + 1));
        check_output();

        // Four sequences with rising channel 0 codes
        $display("[TB] four sequence block");
        base_n = got_cnt[0];
        apply_stimulus(16'h1000, 16'($urandom), 2, 2, 1'b0, 1'b0);
        apply_stimulus(16'h1020, 16'($urandom), 2, 2, 1'b0, 1'b0);
        apply_stimulus(16'h1040, 16'($urandom), 2, 2, 1'b0, 1'b0);
        apply_stimulus(16'h1060, 16'($urandom), 2, 2, 1'b0, 1'b0);
`ifdef XADC_SEQ_AVG_EN
        check("avg_emit_count", 32'(got_cnt[0] - base_n), 32'd1);
        check("avg_value", 32'(got_data[0][got_cnt[0] - 1]), 32'h1030);
`endif
        check_output();

        // Normal operation after everything above
        apply_stimulus(16'hA5A0, 16'h5A50, 2, 4, 1'b0, 1'b0);
        check_output();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
